// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution frame sequencer.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } conv_seq_state_t;

   // Coordinate widths for the default 32x32 image.
   localparam int ROW_W_DEF = 5;
   localparam int COL_W_DEF = 5;

   // Zero-padding border for an odd kernel edge.
   function automatic int pad_of(input int k);
      return (k - 1) / 2;
   endfunction

   // Register width needed to hold coordinates 0..n-1 (at least one bit).
   function automatic int coord_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Fixed-depth valid+payload shift register with synchronous flush.
// Never stalls: it mirrors a non-stallable datapath pipe.
module conv_tag_pipe #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic             r_vld  [DEPTH];
   logic [WIDTH-1:0] r_data [DEPTH];

   // Shift every cycle; flush kills all valid bits including the incoming one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_vld[i]  <= 1'b0;
            r_data[i] <= '0;
         end
      end else begin
         r_vld[0]  <= in_valid & ~flush;
         r_data[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_vld[i]  <= r_vld[i-1] & ~flush;
            r_data[i] <= r_data[i-1];
         end
      end
   end

   assign out_valid = r_vld[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];

endmodule

// File: rtl/conv_sequencer.sv
// Frame-level raster sequencer for the convolution datapath.
// Optional macro CONV_SEQ_STALL_CNT_EN adds a 16-bit saturating stall counter port.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | offering window positions in raster order
// DRAIN | waiting for the convolve pipe to empty
// DONE  | one-cycle completion pulse
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int KERNEL_SIZE  = 3,
   parameter int IMGROW       = 32,
   parameter int IMGCOL       = 32,
   parameter int CONV_LATENCY = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 abort,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 win_valid,
   input  logic                                 win_ready,
   output logic [coord_w(IMGROW)-1:0]           win_row,
   output logic [coord_w(IMGCOL)-1:0]           win_col,
   output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]   pad_mask,
   output logic                                 en_convolve,
   output logic                                 out_valid,
   output logic [coord_w(IMGROW)-1:0]           out_row,
   output logic [coord_w(IMGCOL)-1:0]           out_col
`ifdef CONV_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]                          stall_cnt
`endif
);

   localparam int ROW_W  = coord_w(IMGROW);
   localparam int COL_W  = coord_w(IMGCOL);
   localparam int DRN_W  = coord_w(CONV_LATENCY);
   localparam int PAD    = pad_of(KERNEL_SIZE);
   localparam int MASK_W = KERNEL_SIZE * KERNEL_SIZE;

   conv_seq_state_t   r_state;
   logic [ROW_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic [DRN_W-1:0]  r_drn;
   logic              w_fire;
   logic              w_last_col;
   logic              w_last_pos;
   logic [MASK_W-1:0] w_pad_mask;
   logic [ROW_W+COL_W-1:0] w_tag_out;

   assign w_fire     = (r_state == RUN) & win_ready;
   assign w_last_col = (r_col == COL_W'(IMGCOL - 1));
   assign w_last_pos = w_last_col & (r_row == ROW_W'(IMGROW - 1));

   // Sequencer FSM with raster counters and drain down-counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_drn   <= '0;
      end else if (abort) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            RUN: begin
               if (win_ready) begin
                  if (w_last_pos) begin
                     // Park counters at 0 so the next frame and idle outputs are clean.
                     r_state <= DRAIN;
                     r_row   <= '0;
                     r_col   <= '0;
                     r_drn   <= DRN_W'(CONV_LATENCY - 1);
                  end else if (w_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (r_drn == '0) r_state <= DONE;
               else             r_drn   <= r_drn - 1'b1;
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Mark taps of the current window that fall outside the image.
   always_comb begin
      int rr;
      int cc;
      rr = 0;
      cc = 0;
      w_pad_mask = '0;
      if (r_state == RUN) begin
         for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
               rr = int'(r_row) + i - PAD;
               cc = int'(r_col) + j - PAD;
               if (rr < 0 || rr >= IMGROW || cc < 0 || cc >= IMGCOL)
                  w_pad_mask = w_pad_mask | (MASK_W'(1) << (i * KERNEL_SIZE + j));
            end
         end
      end
   end

`ifdef CONV_SEQ_STALL_CNT_EN
   // Count RUN cycles where the datapath refuses the offered window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (r_state == IDLE && start && !abort) begin
         stall_cnt <= '0;
      end else if (r_state == RUN && !win_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

   conv_tag_pipe #(
      .DEPTH (CONV_LATENCY),
      .WIDTH (ROW_W + COL_W)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort),
      .in_valid  (w_fire),
      .in_data   ({r_row, r_col}),
      .out_valid (out_valid),
      .out_data  (w_tag_out)
   );

   assign out_row     = w_tag_out[ROW_W+COL_W-1:COL_W];
   assign out_col     = w_tag_out[COL_W-1:0];
   assign win_valid   = (r_state == RUN);
   assign en_convolve = w_fire;
   assign busy        = (r_state == RUN) | (r_state == DRAIN);
   assign done        = (r_state == DONE);
   assign win_row     = r_row;
   assign win_col     = r_col;
   assign pad_mask    = w_pad_mask;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer on a 4x4 image, K=3, latency 2.
module tb_conv_sequencer;

   localparam int K = 3;
   localparam int R = 4;
   localparam int C = 4;
   localparam int L = 2;
   localparam int N = R * C;
   localparam int P = (K - 1) / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       win_ready = 1'b0;
   logic       busy, done, win_valid, en_convolve, out_valid;
   logic [1:0] win_row, win_col, out_row, out_col;
   logic [8:0] pad_mask;
`ifdef CONV_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   conv_sequencer #(
      .KERNEL_SIZE (K), .IMGROW (R), .IMGCOL (C), .CONV_LATENCY (L)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .abort (abort),
      .busy (busy), .done (done), .win_valid (win_valid), .win_ready (win_ready),
      .win_row (win_row), .win_col (win_col), .pad_mask (pad_mask),
      .en_convolve (en_convolve), .out_valid (out_valid),
      .out_row (out_row), .out_col (out_col)
`ifdef CONV_SEQ_STALL_CNT_EN
      , .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: frame described by start cycle, raster index and last-fire cycle.
   typedef struct { int due; int r; int c; } res_t;
   res_t sb[$];
   int  cyc = 0;
   bit  m_active = 0;
   int  m_start = 0;
   int  m_idx = 0;
   int  m_last = -1;
   int  m_stall = 0;
   int  n_out = 0;
   int  n_done = 0;
   int  done_cyc = -1;

   function automatic int exp_mask(input int r, input int c);
      int m = 0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            if (r - P + i < 0 || r - P + i >= R || c - P + j < 0 || c - P + j >= C)
               m |= (1 << (i * K + j));
      return m;
   endfunction

   task automatic evaluate();
      bit e_wv, e_fire, e_busy, e_done, e_ov, was_active;
      int er, ec;
      res_t rs;
      e_wv   = m_active && cyc > m_start && m_last < 0;
      e_fire = e_wv && win_ready;
      e_busy = m_active && cyc > m_start && (m_last < 0 || cyc <= m_last + L);
      e_done = m_active && m_last >= 0 && cyc == m_last + L + 1;
      e_ov   = (sb.size() > 0) && (sb[0].due == cyc);
      er = m_idx / C;
      ec = m_idx % C;
      check("win_valid", int'(win_valid), int'(e_wv));
      check("en_convolve", int'(en_convolve), int'(e_fire));
      check("busy", int'(busy), int'(e_busy));
      check("done", int'(done), int'(e_done));
      check("out_valid", int'(out_valid), int'(e_ov));
      if (e_wv) begin
         check("win_row", int'(win_row), er);
         check("win_col", int'(win_col), ec);
         check("pad_mask", int'(pad_mask), exp_mask(er, ec));
      end else begin
         check("pad_mask_idle", int'(pad_mask), 0);
      end
      if (e_ov) begin
         rs = sb.pop_front();
         check("out_row", int'(out_row), rs.r);
         check("out_col", int'(out_col), rs.c);
      end
`ifdef CONV_SEQ_STALL_CNT_EN
      check("stall_cnt", int'(stall_cnt), m_stall);
`endif
      if (out_valid) n_out++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (e_wv && !win_ready && m_stall < 65535) m_stall++;
      was_active = m_active;
      if (abort) begin
         m_active = 0;
         sb.delete();
      end else begin
         if (e_fire) begin
            rs.due = cyc + L; rs.r = er; rs.c = ec;
            sb.push_back(rs);
            m_idx++;
            if (m_idx == N) m_last = cyc;
         end
         if (e_done) m_active = 0;
         if (!was_active && start) begin
            m_active = 1; m_start = cyc; m_idx = 0; m_last = -1; m_stall = 0;
         end
      end
   endtask

   task automatic cycle(input bit st, input bit ab, input bit rdy);
      @(posedge clk);
      #1;
      cyc++;
      start = st; abort = ab; win_ready = rdy;
      @(negedge clk);
      evaluate();
   endtask

   task automatic check_reset_vals();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_win_valid", int'(win_valid), 0);
      check("rst_en_convolve", int'(en_convolve), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_win_pos", int'({win_row, win_col}), 0);
      check("rst_out_pos", int'({out_row, out_col}), 0);
      check("rst_pad_mask", int'(pad_mask), 0);
   endtask

   // mode 0: ready high, 1: 3-cycle stall at (1,2), 2: random ready with stray starts,
   // 3: abort on fire #7, 4: async reset in first drain cycle.
   task automatic run_frame(input int mode);
      int  stalls = 0;
      int  t0;
      bit  st, ab, rdy;
      n_out = 0; n_done = 0; done_cyc = -1;
      cycle(1'b1, 1'b0, 1'b1);
      t0 = cyc;
      for (int k = 0; k < 400 && m_active; k++) begin
         st = 0; ab = 0; rdy = 1;
         case (mode)
            1: if (m_idx == 6 && stalls < 3 && cyc >= m_start) begin rdy = 0; stalls++; end
            2: begin rdy = ($urandom_range(0, 9) < 7); st = ($urandom_range(0, 5) == 0); end
            3: if (m_idx == 6) ab = 1;
            default: ;
         endcase
         cycle(st, ab, rdy);
         if (mode == 4 && m_last >= 0 && cyc == m_last + 1) begin
            #2 rst = 1'b0;
            #1 check_reset_vals();
            m_active = 0; sb.delete(); m_stall = 0;
`ifdef CONV_SEQ_STALL_CNT_EN
            check("rst_stall_cnt", int'(stall_cnt), 0);
`endif
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
         end
      end
      check("frame_terminated", int'(m_active), 0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      case (mode)
         0: begin
            check("start_to_done", done_cyc - t0 + 1, 1 + N + L + 1);
            check("n_results", n_out, N);
            check("n_done", n_done, 1);
         end
         1: begin
            check("n_results_bp", n_out, N);
`ifdef CONV_SEQ_STALL_CNT_EN
            check("stall_total", int'(stall_cnt), 3);
`endif
         end
         2: begin
            check("n_results_rand", n_out, N);
            check("n_done_rand", n_done, 1);
         end
         3, 4: check("no_done", n_done, 0);
         default: ;
      endcase
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_reset_vals();
`ifdef CONV_SEQ_STALL_CNT_EN
      check("rst_stall_cnt", int'(stall_cnt), 0);
`endif
      rst = 1'b1;
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
      run_frame(0);
      run_frame(1);
      run_frame(3);
      run_frame(0);
      for (int k = 0; k < 3; k++) run_frame(2);
      run_frame(4);
      cycle(1'b1, 1'b1, 1'b1);
      check("abort_beats_start", int'(m_active), 0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
      run_frame(0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
